// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding
// and default configuration constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESET_RX = 2'd1,
        ST_HOLDOFF  = 2'd2,
        ST_RUN      = 2'd3
    } rx_state_e;

    localparam int CLK_DIV       = 9;
    localparam int HOLDOFF_TICKS = 200;
    localparam int BYTE_W        = 8;
    localparam int FIFO_DEPTH    = 4;
    localparam int RST_CYCLES    = 4;
    localparam int ERR_CNT_W     = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO with extra-MSB pointers. A push on a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is reported as a drop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int P_DEPTH = FIFO_DEPTH,
    parameter int P_WIDTH = BYTE_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic [P_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output logic [P_WIDTH-1:0] o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_drop
);

    localparam int AW = $clog2(P_DEPTH);

    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [P_WIDTH-1:0] r_mem [P_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_drop  = i_push && w_full && !w_do_pop;

    // Pointer and storage update; reset flushes both so the head reads as zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for the UART receiver: x16 baud tick generation, receiver reset
// ownership with reset/holdoff recovery after framing errors, byte capture
// into a FIFO, saturating error counter and sticky overflow flag.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int P_CLK_DIV       = CLK_DIV,
    parameter int P_FIFO_DEPTH    = FIFO_DEPTH,
    parameter int P_RST_CYCLES    = RST_CYCLES,
    parameter int P_HOLDOFF_TICKS = HOLDOFF_TICKS,
    parameter int P_ERR_CNT_W     = ERR_CNT_W
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clr,
    input  logic [7:0]             rx_Do,
    input  logic                   rx_valid,
    input  logic                   rx_error,
    output logic                   x16_BAUD,
    output logic                   rx_reset,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [P_ERR_CNT_W-1:0] err_count,
    output logic                   overflow
);

    localparam int DIV_W  = $clog2(P_CLK_DIV);
    localparam int HOLD_W = $clog2(P_HOLDOFF_TICKS + 1);
    localparam int RST_W  = $clog2(P_RST_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(P_CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(P_HOLDOFF_TICKS);
    localparam logic [RST_W-1:0]  RST_INIT  = RST_W'(P_RST_CYCLES - 1);

    rx_state_e             r_state;
    rx_state_e             w_state_nxt;
    logic [DIV_W-1:0]      r_div;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_cnt_nxt;
    logic [RST_W-1:0]      r_rst_cnt;
    logic [RST_W-1:0]      w_rst_cnt_nxt;
    logic                  r_valid_q;
    logic                  r_err_q;
    logic [P_ERR_CNT_W-1:0] r_err_count;
    logic                  r_overflow;

    logic w_tick;
    logic w_valid_evt;
    logic w_err_evt;
    logic w_push;
    logic w_err_inc;
    logic w_empty;
    logic w_full;
    logic w_drop;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_valid_evt = rx_valid & ~r_valid_q;
    assign w_err_evt   = rx_error & ~r_err_q;

    assign x16_BAUD  = w_tick;
    assign rx_reset  = (r_state == ST_IDLE) || (r_state == ST_RESET_RX);
    assign m_valid   = ~w_empty;
    assign err_count = r_err_count;
    assign overflow  = r_overflow;

    // Baud divider: free-runs 0..P_CLK_DIV-1 while enabled, parked at zero otherwise.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_div <= '0;
        end else if (!enable) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Delayed copies of the receiver strobes for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_valid_q <= rx_valid;
            r_err_q   <= rx_error;
        end
    end

    // Next-state, recovery counters and capture/error strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_push         = 1'b0;
        w_err_inc      = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt    = ST_HOLDOFF;
                    w_hold_cnt_nxt = HOLD_INIT;
                end
                ST_RESET_RX: begin
                    if (r_rst_cnt == RST_W'(0)) begin
                        w_state_nxt    = ST_HOLDOFF;
                        w_hold_cnt_nxt = HOLD_INIT;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt - RST_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (w_err_evt) begin
                        w_state_nxt   = ST_RESET_RX;
                        w_rst_cnt_nxt = RST_INIT;
                        w_err_inc     = 1'b1;
                    end else if (w_tick) begin
                        // The tick that brings the count to zero releases the receiver.
                        if (r_hold_cnt == HOLD_W'(1)) begin
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_state_nxt = ST_HOLDOFF;
                        end
                        w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                    end else begin
                        w_state_nxt = ST_HOLDOFF;
                    end
                end
                ST_RUN: begin
                    if (w_err_evt) begin
                        // A byte arriving alongside the error is discarded.
                        w_state_nxt   = ST_RESET_RX;
                        w_rst_cnt_nxt = RST_INIT;
                        w_err_inc     = 1'b1;
                    end else if (w_valid_evt) begin
                        w_push = 1'b1;
                    end else begin
                        w_push = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and recovery counter registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_rst_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_rst_cnt  <= w_rst_cnt_nxt;
        end
    end

    // Saturating error counter; clr wins over a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (clr) begin
            r_err_count <= '0;
        end else if (w_err_inc && (r_err_count != '1)) begin
            r_err_count <= r_err_count + P_ERR_CNT_W'(1);
        end else begin
            r_err_count <= r_err_count;
        end
    end

    // Sticky overflow flag; clr wins over a same-cycle drop.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    uart_rx_fifo #(
        .P_DEPTH (P_FIFO_DEPTH),
        .P_WIDTH (BYTE_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (rx_Do),
        .i_pop   (m_ready),
        .o_data  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

endmodule
